// File: rtl/run_controller.sv
// Program loader and run sequencer: streams host words into instruction memory,
// pulses start, then times the processor run until done or a cycle limit.
module run_controller #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned INSTR_W        = 9,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               start,
  input  logic               done,
  output logic               busy,
  output logic               run_done,
  output logic               timeout,
  output logic               overflow,
  output logic [15:0]        cycle_count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SCNT_W  = 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [SCNT_W-1:0] START_LAST  = SCNT_W'(START_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_FINISH
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic [SCNT_W-1:0]   r_start_cnt;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [INSTR_W-1:0]  r_imem_wdata;
  logic                r_start;
  logic                r_run_done;
  logic                r_timeout;
  logic                r_overflow;
  logic [CNT_W-1:0]    r_cycle_count;

  logic                w_ready;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_last_word;
  logic [CNT_W-1:0]    w_cnt_next;

  // A new program always begins at address 0; the top address forces end of program.
  assign w_ready     = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept    = load_valid && w_ready;
  assign w_wr_addr   = (r_state == S_IDLE) ? '0 : r_ptr;
  assign w_last_word = load_last || (w_wr_addr == LAST_ADDR);
  assign w_cnt_next  = r_cycle_count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_start_cnt   <= '0;
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_wdata  <= '0;
      r_start       <= 1'b0;
      r_run_done    <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_accept) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= w_wr_addr;
            r_imem_wdata <= load_data;
            if (r_state == S_IDLE) begin
              r_timeout  <= 1'b0;
              r_overflow <= 1'b0;
            end
            if (w_last_word) begin
              r_ptr         <= w_wr_addr;
              r_state       <= S_START;
              r_start       <= 1'b1;
              r_start_cnt   <= '0;
              r_cycle_count <= '0;
              if (!load_last) begin
                r_overflow <= 1'b1;
              end
            end else begin
              r_ptr   <= w_wr_addr + ADDR_W'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_START: begin
          if (r_start_cnt == START_LAST) begin
            r_start <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_start_cnt <= r_start_cnt + SCNT_W'(1);
          end
        end
        // done wins over the limit; the done cycle itself is not counted.
        S_RUN: begin
          if (done) begin
            r_state    <= S_FINISH;
            r_run_done <= 1'b1;
          end else begin
            r_cycle_count <= w_cnt_next;
            if (w_cnt_next == TIMEOUT_VAL) begin
              r_timeout  <= 1'b1;
              r_state    <= S_FINISH;
              r_run_done <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          r_run_done <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready  = w_ready;
  assign busy        = (r_state != S_IDLE);
  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign start       = r_start;
  assign run_done    = r_run_done;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign cycle_count = r_cycle_count;

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width; depth = 2**ADDR_W.
REQ-002 SHALL have parameter INSTR_W, default 9, meaning instruction word width.
REQ-003 SHALL have parameter START_CYCLES, default 2, meaning number of cycles `start` is held high; legal range 1-15.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning run-cycle limit; must be below 2**16.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port load_valid  input  1  host offers an instruction word.
REQ-008 SHALL have port load_data  input  INSTR_W  instruction word.
REQ-009 SHALL have port load_last  input  1  marks the final word of the program.
REQ-010 SHALL have port load_ready  output  1  controller accepts a word this cycle.
REQ-011 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port imem_addr  output  ADDR_W  instruction-memory write address.
REQ-013 SHALL have port imem_wdata  output  INSTR_W  instruction-memory write data.
REQ-014 SHALL have port start  output  1  processor start request.
REQ-015 SHALL have port done  input  1  processor completion flag, level-sensitive.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port run_done  output  1  one-cycle pulse when a run ends.
REQ-018 SHALL have port timeout  output  1  sticky flag: last run hit TIMEOUT_CYCLES.
REQ-019 SHALL have port overflow  output  1  sticky flag: program was truncated at memory depth.
REQ-020 SHALL have port cycle_count  output  16  number of RUN cycles in the current or last run.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, START, RUN and FINISH.
REQ-022 IDLE -> LOAD: on the first cycle with load_valid=1; that word is accepted (load_ready=1 in IDLE).
REQ-023 Word acceptance:
- Condition: load_valid & load_ready.
- Registered, one-cycle latency: imem_we=1, imem_wdata=load_data and imem_addr=write pointer on the next cycle.
- After each accepted word, the pointer increments.
REQ-024 load_ready SHALL be 1 in IDLE and LOAD only, and 0 in every other state.
REQ-025 Starting a new program from IDLE SHALL clear the write pointer to 0, and clear timeout and overflow.
REQ-026 LOAD -> START after an accepted word with load_last=1.
REQ-027 Depth limit: if the word at address 2**ADDR_W-1 is accepted with load_last=0:
- it is treated as last;
- overflow is set;
- the FSM goes to START;
- the pointer does not wrap.
REQ-028 START behaviour:
- start=1 for exactly START_CYCLES consecutive cycles;
- then start=0 and FSM -> RUN;
- cycle_count is cleared to 0 on entry to START.
REQ-029 RUN behaviour:
- cycle_count increments by 1 each cycle;
- on done=1, FSM -> FINISH with cycle_count frozen, excluding the done cycle.
REQ-030 If done is already 1 on the first RUN cycle, it SHALL be treated as completion (cycle_count=0).
REQ-031 If cycle_count reaches TIMEOUT_CYCLES in RUN without done, timeout is set and FSM -> FINISH; cycle_count holds TIMEOUT_CYCLES.
REQ-032 FINISH SHALL last one cycle with run_done=1, then return to IDLE.
REQ-033 In FINISH, load_valid is ignored (load_ready=0).
REQ-034 cycle_count, timeout and overflow SHALL hold their values in IDLE until the next program load begins.
REQ-035 load_valid without load_ready SHALL have no effect; the host must hold data until accepted.
REQ-036 imem_we SHALL never be 1 outside the cycle following an acceptance.

Reset
REQ-037 While reset=0 (asynchronously), the block SHALL force:
- state=IDLE;
- start, imem_we, busy, run_done, timeout, overflow = 0;
- imem_addr, imem_wdata, cycle_count and write pointer = 0.
REQ-038 Reset asserted mid-LOAD, mid-START or mid-RUN SHALL abort immediately: start drops to 0 with no run_done pulse.
REQ-039 After reset deasserts, load_ready SHALL be 1 on the first clock edge.

Verification
REQ-040 Load 3 words 0x101, 0x0A5, 0x1FF (last on 3rd) with done=0 -> imem writes at addresses 0, 1, 2 with matching data; start high 2 cycles; busy=1.
REQ-041 Same load, then done=1 after 10 RUN cycles -> cycle_count=10, one run_done pulse, state IDLE, timeout=0.
REQ-042 ADDR_W=2, 5 words with no last -> 4 writes (addresses 0-3), overflow=1, 5th word stalls (load_ready=0), start issued.
REQ-043 TIMEOUT_CYCLES=8, done held 0 -> timeout=1 and cycle_count=8 at run_done; a new load clears timeout.
REQ-044 done=1 already at RUN entry -> cycle_count=0, run_done the next cycle.
REQ-045 reset=0 pulsed during RUN at cycle 5 -> all outputs 0 asynchronously, no run_done, load_ready=1 after release.
